// File: rtl/wb_bridge_pkg.sv
// Shared state encoding and defaults for the CPU-to-Wishbone bridge.
package wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } bridge_state_t;

   localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Per-bus-cycle watchdog: cleared when a cycle opens, counts while cyc is high.
module wb_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic i_reset,
   input  logic i_start,
   input  logic i_run,
   output logic o_expired
);

   localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (i_reset || i_start) cnt <= '0;
      else if (i_run)         cnt <= cnt + 16'd1;
   end

   // Fires in the TIMEOUT-th cycle that cyc is high.
   assign o_expired = i_run && (cnt == LAST);

endmodule

// File: rtl/wb_mem_bridge.sv
// CPU native memory port to Wishbone B4 pipelined master, one request in
// flight, with a bus-cycle timeout and sticky error capture.
module wb_mem_bridge
   import wb_bridge_pkg::*;
#(
   parameter int              AW        = 32,
   parameter int              DW        = 32,
   parameter logic [AW-1:0]   BASE_ADDR = AW'(32'h8000_0000),
   parameter logic [AW-1:0]   ADDR_MASK = AW'(32'hFFFF_0000),
   parameter int              TIMEOUT   = 255,
   parameter logic [DW-1:0]   ERR_RDATA = DW'(ERR_RDATA_DEF),
   localparam int             SW        = DW / 8
) (
   input  logic          clk,
   input  logic          i_reset,
   input  logic          i_mem_valid,
   input  logic [AW-1:0] i_mem_addr,
   input  logic [DW-1:0] i_mem_wdata,
   input  logic [SW-1:0] i_mem_wstrb,
   output logic          o_mem_ready,
   output logic [DW-1:0] o_mem_rdata,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-1:0] o_wb_addr,
   output logic [DW-1:0] o_wb_data,
   output logic [SW-1:0] o_wb_sel,
   input  logic          i_wb_ack,
   input  logic          i_wb_err,
   input  logic          i_wb_stall,
   input  logic [DW-1:0] i_wb_data,
   output logic          o_sel,
   output logic          o_err_flag,
   output logic [AW-1:0] o_err_addr,
   output logic          o_err_timeout,
   input  logic          i_err_clr
);

   bridge_state_t state, state_d;

   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic [SW-1:0] sel_q;
   logic          we_q;
   logic          start, respond, bus_ack, bus_err;
   logic          expired, tmo, fail, done;

   assign o_sel = i_mem_valid && ((i_mem_addr & ADDR_MASK) == BASE_ADDR);

   assign o_wb_cyc  = (state == REQ) || (state == WAIT);
   assign o_wb_stb  = (state == REQ);
   assign o_wb_we   = o_wb_cyc && we_q;
   assign o_wb_addr = addr_q;
   assign o_wb_data = data_q;
   assign o_wb_sel  = sel_q;

   assign start = (state == IDLE) && o_sel;

   // A stalled strobe has not been accepted, so no response can belong to it.
   assign respond = (state == WAIT) || ((state == REQ) && !i_wb_stall);
   assign bus_err = respond && i_wb_err;
   assign bus_ack = respond && i_wb_ack && !i_wb_err;
   assign tmo     = expired && !bus_ack && !bus_err;
   assign fail    = bus_err || tmo;
   assign done    = bus_ack || fail;

   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk       (clk),
      .i_reset   (i_reset),
      .i_start   (start),
      .i_run     (o_wb_cyc),
      .o_expired (expired)
   );

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (o_sel) state_d = REQ;
         REQ:     if (done) state_d = DONE;
                  else if (!i_wb_stall) state_d = WAIT;
         WAIT:    if (done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state         <= IDLE;
         o_mem_ready   <= 1'b0;
         o_mem_rdata   <= '0;
         o_err_flag    <= 1'b0;
         o_err_addr    <= '0;
         o_err_timeout <= 1'b0;
      end else begin
         state       <= state_d;
         o_mem_ready <= done;
         if (done)
            o_mem_rdata <= fail ? ERR_RDATA : (we_q ? '0 : i_wb_data);
         // A new error outranks a simultaneous clear.
         if (fail) begin
            o_err_flag    <= 1'b1;
            o_err_timeout <= (o_err_timeout && !i_err_clr) || tmo;
            if (!o_err_flag || i_err_clr) o_err_addr <= addr_q;
         end else if (i_err_clr) begin
            o_err_flag    <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_addr    <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         addr_q <= i_mem_addr;
         data_q <= i_mem_wdata;
         we_q   <= |i_mem_wstrb;
         sel_q  <= (|i_mem_wstrb) ? i_mem_wstrb : '1;
      end
   end

endmodule
